// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage with a single outstanding memory request,
// an IF/ID pipeline register and a one-entry hold buffer for stalled decode.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   stall                     decode not accepting; IF/ID is held
//   redirect, redirect_pc     taken branch/jump pulse and its target
//   imem_req, imem_addr       fetch request strobe and address
//   imem_rvalid, imem_rdata   instruction memory response
//   if_valid, if_instr,       IF/ID register contents
//   if_pc, if_pc_plus4
//   opcode, funct             decode fields of if_instr (combinational)
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic [5:0]  opcode,
   output logic [5:0]  funct
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] hold_instr;
   logic [31:0] hold_pc;

   // pc is only advanced once a response has been accepted, so it equals the
   // address of the request in flight for the whole REQ/WAIT window.
   assign imem_addr = pc;
   assign opcode    = if_instr[31:26];
   assign funct     = if_instr[5:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         imem_req    <= 1'b0;
         if_valid    <= 1'b0;
         if_instr    <= '0;
         if_pc       <= '0;
         if_pc_plus4 <= '0;
         hold_instr  <= '0;
         hold_pc     <= '0;
      end else begin
         imem_req <= 1'b0;
         if (redirect) begin
            // Hold buffer content is dead once the state leaves HOLD.
            pc       <= redirect_pc & 32'hFFFF_FFFC;
            if_valid <= 1'b0;
            case (state)
               REQ: state <= DRAIN;
               WAIT, DRAIN: begin
                  if (imem_rvalid) begin
                     state    <= REQ;
                     imem_req <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end
               default: begin
                  state    <= REQ;
                  imem_req <= 1'b1;
               end
            endcase
         end else begin
            // Decode took the current word; a load below overrides this clear.
            if (if_valid && !stall)
               if_valid <= 1'b0;
            case (state)
               IDLE: begin
                  state    <= REQ;
                  imem_req <= 1'b1;
               end
               REQ: state <= WAIT;
               WAIT: begin
                  if (imem_rvalid) begin
                     pc <= pc + 32'd4;
                     if (!if_valid || !stall) begin
                        if_valid    <= 1'b1;
                        if_instr    <= imem_rdata;
                        if_pc       <= pc;
                        if_pc_plus4 <= pc + 32'd4;
                        state       <= REQ;
                        imem_req    <= 1'b1;
                     end else begin
                        hold_instr <= imem_rdata;
                        hold_pc    <= pc;
                        state      <= HOLD;
                     end
                  end
               end
               HOLD: begin
                  if (!stall) begin
                     if_valid    <= 1'b1;
                     if_instr    <= hold_instr;
                     if_pc       <= hold_pc;
                     if_pc_plus4 <= hold_pc + 32'd4;
                     state       <= REQ;
                     imem_req    <= 1'b1;
                  end
               end
               DRAIN: begin
                  if (imem_rvalid) begin
                     state    <= REQ;
                     imem_req <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic [5:0]  opcode;
   logic [5:0]  funct;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // memory model controls
   int unsigned mem_delay = 1;
   bit          mem_rand = 1'b0;
   bit          mem_const = 1'b0;
   bit          mem_pending = 1'b0;
   int unsigned mem_cnt = 0;
   logic [31:0] mem_addr = '0;
   int unsigned mem_overlap = 0;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
      .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
      .opcode(opcode), .funct(funct)
   );

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'hC3A5_965A;
   endfunction

   // Instruction memory: answers each request after a delay of 1..3 cycles.
   initial begin : memory
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(posedge clk); #1;
         imem_rvalid = 1'b0;
         if (mem_pending) begin
            if (mem_cnt <= 1) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_const ? 32'h2008_0005 : memf(mem_addr);
               mem_pending = 1'b0;
            end else begin
               mem_cnt--;
            end
         end
         if (imem_req === 1'b1) begin
            if (mem_pending) mem_overlap++;
            mem_pending = 1'b1;
            mem_addr    = imem_addr;
            mem_cnt     = mem_rand ? $urandom_range(1, 3) : mem_delay;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic do_reset();
      stall = 1'b0; redirect = 1'b0; redirect_pc = '0; rst = 1'b1;
      repeat (5) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b exp 0", imem_req); end
      n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", if_valid); end
      n_vec++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h exp 0", if_instr); end
      n_vec++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h exp 0", if_pc); end
      n_vec++; if (if_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL reset_pc4 got %h exp 0", if_pc_plus4); end
   endtask

   task automatic test_basic();
      mem_const = 1'b1; mem_delay = 1;
      do_reset();
      tick();
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL basic_first_req got %b/%h exp 1/0", imem_req, imem_addr); end
      tick(); tick();
      n_vec++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b exp 1", if_valid); end
      n_vec++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL basic_pc got %h exp 0", if_pc); end
      n_vec++; if (if_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL basic_pc4 got %h exp 4", if_pc_plus4); end
      n_vec++; if (opcode !== 6'b001000) begin n_err++; $display("FAIL basic_opcode got %b exp 001000", opcode); end
      n_vec++; if (funct !== 6'b000101) begin n_err++; $display("FAIL basic_funct got %b exp 000101", funct); end
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_err++; $display("FAIL basic_second_req got %b/%h exp 1/4", imem_req, imem_addr); end
      tick(); tick();
      n_vec++; if (if_pc !== 32'h4 || if_valid !== 1'b1) begin n_err++; $display("FAIL basic_second_pc got %h/%b exp 4/1", if_pc, if_valid); end
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_err++; $display("FAIL basic_third_req got %b/%h exp 1/8", imem_req, imem_addr); end
      mem_const = 1'b0;
   endtask

   task automatic test_hold();
      mem_delay = 1;
      do_reset();
      tick(); tick(); tick();
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL hold_req[%0d] got %b exp 0", i, imem_req); end
         n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin n_err++; $display("FAIL hold_ifid[%0d] got %b/%h exp 1/0", i, if_valid, if_pc); end
         n_vec++; if (if_instr !== memf(32'h0)) begin n_err++; $display("FAIL hold_instr[%0d] got %h exp %h", i, if_instr, memf(32'h0)); end
      end
      stall = 1'b0;
      tick();
      n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin n_err++; $display("FAIL hold_release_pc got %b/%h exp 1/4", if_valid, if_pc); end
      n_vec++; if (if_instr !== memf(32'h4)) begin n_err++; $display("FAIL hold_release_instr got %h exp %h", if_instr, memf(32'h4)); end
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_err++; $display("FAIL hold_release_req got %b/%h exp 1/8", imem_req, imem_addr); end
   endtask

   task automatic test_redirect_wait();
      mem_delay = 2;
      do_reset();
      tick(); tick();
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      tick();
      redirect = 1'b0;
      n_vec++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL rdw_drain got %b/%b exp 0/0", if_valid, imem_req); end
      tick();
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL rdw_req got %b/%h exp 1/100", imem_req, imem_addr); end
      n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rdw_dropped got %b exp 0", if_valid); end
      tick(); tick(); tick();
      n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== memf(32'h100)) begin n_err++; $display("FAIL rdw_target got %b/%h/%h exp 1/100/%h", if_valid, if_pc, if_instr, memf(32'h100)); end
   endtask

   task automatic test_redirect_rvalid();
      mem_delay = 1;
      do_reset();
      tick(); tick();
      redirect = 1'b1; redirect_pc = 32'h0000_2000;
      tick();
      redirect = 1'b0;
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin n_err++; $display("FAIL rdr_req got %b/%h exp 1/2000", imem_req, imem_addr); end
      n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rdr_discard got %b exp 0", if_valid); end
      tick(); tick();
      n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h2000) begin n_err++; $display("FAIL rdr_target got %b/%h exp 1/2000", if_valid, if_pc); end
   endtask

   task automatic test_wrap();
      mem_delay = 1;
      do_reset();
      tick(); tick();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      tick();
      redirect = 1'b0;
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_req got %b/%h exp 1/fffffffc", imem_req, imem_addr); end
      tick(); tick();
      n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc got %b/%h exp 1/fffffffc", if_valid, if_pc); end
      n_vec++; if (if_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4 got %h exp 0", if_pc_plus4); end
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next_req got %b/%h exp 1/0", imem_req, imem_addr); end
   endtask

   task automatic test_reset_stale();
      bit seen;
      mem_delay = 3;
      do_reset();
      tick(); tick();
      rst = 1'b1;
      #1;
      n_vec++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL stale_async got %b/%b exp 0/0", if_valid, imem_req); end
      tick(); tick();
      rst = 1'b0;
      tick();
      n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL stale_ignored got %b exp 0", if_valid); end
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL stale_req got %b/%h exp 1/0", imem_req, imem_addr); end
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         seen = (if_valid === 1'b1);
      end
      n_vec++; if (!seen || if_pc !== 32'h0 || if_instr !== memf(32'h0)) begin n_err++; $display("FAIL stale_first got %b/%h/%h exp 1/0/%h", seen, if_pc, if_instr, memf(32'h0)); end
   endtask

   task automatic test_random();
      logic [31:0] exp_fetch, exp_cons, pre_pc, pre_instr, pre_rpc;
      bit          pre_valid, pre_stall, pre_redirect;
      int unsigned n_cons;
      mem_rand = 1'b1;
      do_reset();
      exp_fetch = 32'h0; exp_cons = 32'h0; n_cons = 0;
      pre_valid = 1'b0; pre_stall = 1'b0; pre_redirect = 1'b0;
      pre_pc = '0; pre_instr = '0; pre_rpc = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         tick();
         // decode sees a consecutive address stream, restarting at each redirect target
         if (pre_valid && !pre_stall) begin
            n_vec++; if (pre_pc !== exp_cons) begin n_err++; $display("FAIL rnd_stream cyc %0d got %h exp %h", cyc, pre_pc, exp_cons); end
            exp_cons = pre_pc + 32'd4;
            n_cons++;
         end
         if (pre_redirect) begin
            exp_fetch = pre_rpc & 32'hFFFF_FFFC;
            exp_cons  = pre_rpc & 32'hFFFF_FFFC;
            n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rnd_flush cyc %0d got %b exp 0", cyc, if_valid); end
         end
         if (imem_req === 1'b1) begin
            n_vec++; if (imem_addr !== exp_fetch) begin n_err++; $display("FAIL rnd_fetch cyc %0d got %h exp %h", cyc, imem_addr, exp_fetch); end
            exp_fetch = imem_addr + 32'd4;
         end
         if (if_valid === 1'b1) begin
            n_vec++; if (if_instr !== memf(if_pc)) begin n_err++; $display("FAIL rnd_instr cyc %0d got %h exp %h", cyc, if_instr, memf(if_pc)); end
            n_vec++; if (if_pc_plus4 !== if_pc + 32'd4) begin n_err++; $display("FAIL rnd_pc4 cyc %0d got %h exp %h", cyc, if_pc_plus4, if_pc + 32'd4); end
            n_vec++; if (opcode !== if_instr[31:26] || funct !== if_instr[5:0]) begin n_err++; $display("FAIL rnd_fields cyc %0d got %b/%b", cyc, opcode, funct); end
         end
         if (pre_valid && pre_stall && !pre_redirect) begin
            n_vec++; if (if_valid !== 1'b1 || if_pc !== pre_pc || if_instr !== pre_instr) begin n_err++; $display("FAIL rnd_stall cyc %0d got %b/%h/%h exp 1/%h/%h", cyc, if_valid, if_pc, if_instr, pre_pc, pre_instr); end
         end
         stall       = ($urandom_range(0, 9) < 4);
         redirect    = ($urandom_range(0, 99) < 6);
         redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         pre_valid    = (if_valid === 1'b1);
         pre_stall    = stall;
         pre_redirect = redirect;
         pre_rpc      = redirect_pc;
         pre_pc       = if_pc;
         pre_instr    = if_instr;
      end
      stall = 1'b0; redirect = 1'b0;
      n_vec++; if (n_cons < 100) begin n_err++; $display("FAIL rnd_progress got %0d consumed exp >= 100", n_cons); end
      n_vec++; if (mem_overlap !== 0) begin n_err++; $display("FAIL rnd_outstanding got %0d overlaps exp 0", mem_overlap); end
      mem_rand = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_redirect_wait();
      test_redirect_rvalid();
      test_wrap();
      test_reset_stale();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
